// File: rtl/boot_loader_if.sv
// Byte-stream and memory-write bundle between the boot loader and its environment.
// The master modport is the loader side; the slave modport is the UART/memory side.
interface boot_loader_if #(
    parameter int IA = 10,
    parameter int DA = 10
);
    logic          rvalid_i;
    logic          rready_o;
    logic [7:0]    rdata_i;
    logic          imem_we_o;
    logic [IA-1:0] imem_addr_o;
    logic          dmem_we_o;
    logic [DA-1:0] dmem_addr_o;
    logic [31:0]   wdata_o;

    modport master (
        input  rvalid_i, rdata_i,
        output rready_o, imem_we_o, imem_addr_o, dmem_we_o, dmem_addr_o, wdata_o
    );

    modport slave (
        output rvalid_i, rdata_i,
        input  rready_o, imem_we_o, imem_addr_o, dmem_we_o, dmem_addr_o, wdata_o
    );
endinterface

// File: rtl/boot_loader.sv
// Assembles little-endian UART bytes into 32-bit words, writes IMEM then DMEM,
// and releases the CPU from reset once both memories are loaded.
module boot_loader #(
    parameter int IMEM_ENTRIES = 1024,
    parameter int DMEM_ENTRIES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    boot_loader_if.master ldr,
    output logic          cpu_rst_o,
    output logic          done_o
);
    localparam int IA = (IMEM_ENTRIES > 1) ? $clog2(IMEM_ENTRIES) : 1;
    localparam int DA = (DMEM_ENTRIES > 1) ? $clog2(DMEM_ENTRIES) : 1;
    localparam int WA = (IA > DA) ? IA : DA;
    localparam logic [WA-1:0] IMEM_LAST = WA'(IMEM_ENTRIES - 1);
    localparam logic [WA-1:0] DMEM_LAST = WA'(DMEM_ENTRIES - 1);

    typedef enum logic [1:0] {
        LOAD_IMEM = 2'd0,
        LOAD_DMEM = 2'd1,
        DONE      = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   part_q, part_d;
    logic [WA-1:0] word_cnt_q, word_cnt_d;
    logic          imem_we_q, imem_we_d;
    logic          dmem_we_q, dmem_we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          cpu_rst_q, cpu_rst_d;
    logic          accept;

    assign ldr.rready_o = (state_q != DONE);
    assign accept       = ldr.rvalid_i & ldr.rready_o;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        part_d     = part_q;
        word_cnt_d = word_cnt_q;
        imem_we_d  = 1'b0;
        dmem_we_d  = 1'b0;
        wdata_d    = wdata_q;
        done_d     = done_q;
        cpu_rst_d  = cpu_rst_q;

        // Retire the strobe of this cycle: step the word index or hand over to the next region.
        if (imem_we_q) begin
            if (word_cnt_q == IMEM_LAST) begin
                state_d    = LOAD_DMEM;
                word_cnt_d = '0;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end else if (dmem_we_q) begin
            if (word_cnt_q == DMEM_LAST) begin
                state_d   = DONE;
                done_d    = 1'b1;
                cpu_rst_d = 1'b0;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
                2'd0: part_d[7:0]   = ldr.rdata_i;
                2'd1: part_d[15:8]  = ldr.rdata_i;
                2'd2: part_d[23:16] = ldr.rdata_i;
                default: begin
                    wdata_d   = {ldr.rdata_i, part_q};
                    imem_we_d = (state_q == LOAD_IMEM);
                    dmem_we_d = (state_q == LOAD_DMEM);
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LOAD_IMEM;
            byte_cnt_q <= '0;
            part_q     <= '0;
            word_cnt_q <= '0;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            part_q     <= part_d;
            word_cnt_q <= word_cnt_d;
            imem_we_q  <= imem_we_d;
            dmem_we_q  <= dmem_we_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    assign ldr.imem_we_o   = imem_we_q;
    assign ldr.dmem_we_o   = dmem_we_q;
    assign ldr.imem_addr_o = word_cnt_q[IA-1:0];
    assign ldr.dmem_addr_o = word_cnt_q[DA-1:0];
    assign ldr.wdata_o     = wdata_q;
    assign cpu_rst_o       = cpu_rst_q;
    assign done_o          = done_q;
endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader (2 IMEM + 2 DMEM words) against a byte-stream
// reference model that predicts every memory write, its address, data and cycle.
module tb_boot_loader;
    localparam int I_N = 2;
    localparam int D_N = 2;
    localparam int TOTAL_BYTES = 4 * (I_N + D_N);

    logic clk = 1'b0;
    logic rst;
    logic cpu_rst;
    logic done;

    boot_loader_if #(.IA(1), .DA(1)) ldr ();

    boot_loader #(
        .IMEM_ENTRIES(I_N),
        .DMEM_ENTRIES(D_N)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .ldr      (ldr.master),
        .cpu_rst_o(cpu_rst),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_d;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    wr_t b2b_q[$];

    int          n_acc;
    logic [31:0] asm_word;

    // Reference: byte n belongs to word n/4 at lane n%4; words 0..I_N-1 go to IMEM, the rest to DMEM.
    task automatic model_accept(input logic [7:0] b, input int c);
        int k;
        int w;
        wr_t e;
        k = n_acc % 4;
        w = n_acc / 4;
        if (k == 0) asm_word = {24'd0, b};
        else        asm_word = asm_word | ({24'd0, b} << (8 * k));
        if (k == 3) begin
            e.is_d = (w >= I_N);
            e.addr = (w < I_N) ? w : w - I_N;
            e.data = asm_word;
            e.cyc  = c;
            exp_q.push_back(e);
        end
        n_acc++;
    endtask

    logic prev_i = 1'b0;
    logic prev_d = 1'b0;
    logic prev_done = 1'b0;
    int   last_d_cyc = -1;
    int   done_rise_cyc = -1;

    always @(negedge clk) begin
        wr_t o;
        if (!rst) begin
            if (ldr.imem_we_o) begin
                o.is_d = 1'b0; o.addr = int'(ldr.imem_addr_o); o.data = ldr.wdata_o; o.cyc = cyc;
                obs_q.push_back(o);
            end
            if (ldr.dmem_we_o) begin
                o.is_d = 1'b1; o.addr = int'(ldr.dmem_addr_o); o.data = ldr.wdata_o; o.cyc = cyc;
                obs_q.push_back(o);
                if (int'(ldr.dmem_addr_o) == D_N - 1) last_d_cyc = cyc;
            end
            if (done && !prev_done) done_rise_cyc = cyc;
        end
        check("we_exclusive", ldr.imem_we_o & ldr.dmem_we_o, 0);
        check("we_one_cycle", (ldr.imem_we_o & prev_i) | (ldr.dmem_we_o & prev_d), 0);
        check("done_vs_cpu_rst", done, !cpu_rst);
        prev_i    = ldr.imem_we_o;
        prev_d    = ldr.dmem_we_o;
        prev_done = done;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2;
        check("rst_imem_we", ldr.imem_we_o, 0);
        check("rst_dmem_we", ldr.dmem_we_o, 0);
        check("rst_wdata", ldr.wdata_o, 0);
        check("rst_imem_addr", ldr.imem_addr_o, 0);
        check("rst_dmem_addr", ldr.dmem_addr_o, 0);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rready", ldr.rready_o, 1);
        obs_q.delete();
        exp_q.delete();
        n_acc         = 0;
        asm_word      = '0;
        last_d_cyc    = -1;
        done_rise_cyc = -1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit exp_rdy;
        ldr.rvalid_i = 1'b1;
        ldr.rdata_i  = b;
        exp_rdy = (n_acc < TOTAL_BYTES);
        check("rready", ldr.rready_o, exp_rdy);
        @(posedge clk);
        #1;
        ldr.rvalid_i = 1'b0;
        if (exp_rdy) model_accept(b, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_mem"}, obs_q[i].is_d, exp_q[i].is_d);
            check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
            check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
            check({tag, "_cycle"}, obs_q[i].cyc, exp_q[i].cyc);
        end
    endtask

    logic [7:0]  bytes [TOTAL_BYTES];
    logic [31:0] held_wdata;
    logic        held_iaddr;
    logic        held_daddr;

    initial begin
        rst          = 1'b1;
        ldr.rvalid_i = 1'b0;
        ldr.rdata_i  = 8'h00;

        // Single word to IMEM.
        do_reset();
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        idle(3);
        compare_writes("one_word");
        if (obs_q.size() > 0) check("one_word_value", obs_q[0].data, 32'h12345678);

        // Full image back-to-back.
        for (int i = 0; i < TOTAL_BYTES; i++) bytes[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < TOTAL_BYTES; i++) send_byte(bytes[i]);
        idle(4);
        compare_writes("b2b");
        b2b_q = obs_q;
        check("b2b_done", done, 1);
        check("b2b_cpu_rst", cpu_rst, 0);
        check("b2b_done_timing", done_rise_cyc, last_d_cyc + 1);

        // Bytes offered in DONE are refused and change nothing.
        held_wdata = ldr.wdata_o;
        held_iaddr = ldr.imem_addr_o;
        held_daddr = ldr.dmem_addr_o;
        for (int i = 0; i < 10; i++) send_byte(8'hFF);
        idle(2);
        check("done_nwrites", obs_q.size(), I_N + D_N);
        check("done_wdata", ldr.wdata_o, held_wdata);
        check("done_imem_addr", ldr.imem_addr_o, held_iaddr);
        check("done_dmem_addr", ldr.dmem_addr_o, held_daddr);
        check("done_held", done, 1);

        // Same image with random gaps.
        do_reset();
        for (int i = 0; i < TOTAL_BYTES; i++) begin
            idle($urandom_range(0, 20));
            send_byte(bytes[i]);
        end
        idle(4);
        compare_writes("sparse");
        check("sparse_vs_b2b_n", obs_q.size(), b2b_q.size());
        for (int i = 0; i < obs_q.size() && i < b2b_q.size(); i++) begin
            check("sparse_vs_b2b_addr", obs_q[i].addr, b2b_q[i].addr);
            check("sparse_vs_b2b_data", obs_q[i].data, b2b_q[i].data);
        end
        check("sparse_done", done, 1);

        // Reset mid-word discards the partial word.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        idle(1);
        check("mid_pre_nwrites", obs_q.size(), 1);
        do_reset();
        idle(8);
        check("mid_no_strobe", obs_q.size(), 0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(3);
        compare_writes("after_rst");
        if (obs_q.size() > 0) check("after_rst_value", obs_q[0].data, 32'hDDCCBBAA);

        // Extra random full loads with short random gaps.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < TOTAL_BYTES; i++) begin
                idle($urandom_range(0, 3));
                send_byte(8'($urandom));
            end
            idle(4);
            compare_writes("rand_load");
            check("rand_done", done, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter IMEM_ENTRIES, default 1024, number of 32-bit instruction-memory words to load (>=1).
REQ-002 Parameter DMEM_ENTRIES, default 1024, number of 32-bit data-memory words to load (>=1).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 rvalid_i  input  1  received UART byte valid.
REQ-006 rready_o  output  1  loader ready to accept a byte.
REQ-007 rdata_i  input  8  received UART byte.
REQ-008 imem_we_o  output  1  instruction-memory word write strobe.
REQ-009 imem_addr_o  output  IA=max(1,clog2(IMEM_ENTRIES))  instruction-memory word index.
REQ-010 dmem_we_o  output  1  data-memory word write strobe.
REQ-011 dmem_addr_o  output  DA=max(1,clog2(DMEM_ENTRIES))  data-memory word index.
REQ-012 wdata_o  output  32  assembled word, shared by both memories.
REQ-013 cpu_rst_o  output  1  CPU held in reset while high.
REQ-014 done_o  output  1  load complete.

Function
REQ-015 States: LOAD_IMEM, LOAD_DMEM, DONE; the block is in LOAD_IMEM after reset.
REQ-016 Byte handshake: byte accepted on a rising edge where rvalid_i & rready_o; rready_o = 1 in LOAD_IMEM/LOAD_DMEM, 0 in DONE.
REQ-017 Byte counter (2 bits) counts accepted bytes mod 4; byte k (0..3) is stored into word bits [8k+7:8k] (little-endian, first byte = LSB).
REQ-018 Word complete when the 4th byte is accepted; the next cycle asserts exactly one write strobe for one cycle, wdata_o = assembled word, address = current word counter.
REQ-019 Strobe selection: imem_we_o if the word completed in LOAD_IMEM, dmem_we_o if in LOAD_DMEM; never both in the same cycle.
REQ-020 wdata_o and addresses hold stable during the strobe cycle; values outside strobe cycles are don't-care for the memories but deterministic.
REQ-021 Word counter increments on each strobe; imem word counter spans 0..IMEM_ENTRIES-1 and dmem word counter spans 0..DMEM_ENTRIES-1, with no wrap.
REQ-022 After the imem strobe for word IMEM_ENTRIES-1: state -> LOAD_DMEM, word counter -> 0, in the strobe cycle.
REQ-023 After the dmem strobe for word DMEM_ENTRIES-1: state -> DONE in the strobe cycle.
REQ-024 A byte accepted in the same cycle as a write strobe is counted normally (no stall, full throughput of 1 byte/cycle).
REQ-025 Bytes presented in DONE are not accepted and have no effect; DONE is left only by reset.
REQ-026 cpu_rst_o = 1 and done_o = 0 in LOAD states; cpu_rst_o = 0 and done_o = 1 registered, from the first cycle in DONE.

Reset
REQ-027 On rst_i high, asynchronously: state = LOAD_IMEM, byte and word counters = 0, imem_we_o = dmem_we_o = 0, wdata_o = 0, addresses = 0, cpu_rst_o = 1, done_o = 0; rready_o = 1 after release.
REQ-028 Reset mid-load discards any partial word and pending strobe; loading restarts at imem word 0.

Verification (IMEM_ENTRIES=2, DMEM_ENTRIES=2)
REQ-029 Bytes 78,56,34,12 to imem -> one imem_we_o pulse, addr 0, wdata_o 0x12345678, cycle after 4th byte.
REQ-030 16 bytes back-to-back, 1 per cycle -> imem writes addr 0,1 then dmem writes addr 0,1; done_o=1 and cpu_rst_o=0 from the cycle of the last dmem strobe's next edge.
REQ-031 Sparse bytes (random gaps 0-20 cycles) -> identical writes and data as back-to-back case.
REQ-032 After DONE, rvalid_i held high with 0xFF -> rready_o=0, no strobes, outputs unchanged.
REQ-033 rst_i pulsed after 6 bytes -> no further strobe from the partial word; next 4 bytes AA,BB,CC,DD -> imem addr 0, wdata 0xDDCCBBAA.
REQ-034 Assertion checks throughout: imem_we_o & dmem_we_o never both 1; strobes never exceed 1 cycle; done_o == ~cpu_rst_o.
